// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add multiply-accumulate, result = A*B + C.
// One multiplier bit is consumed per clock, so every operation takes exactly
// DW cycles in BUSY regardless of operand values. Valid/ready on both sides.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for operands, in_ready high
//   BUSY   | shift-add loop, one multiplier bit per clock
//   DONE   | result presented, out_valid high until out_ready
module mul_add_seq #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     multiplicand,
    input  logic [DW-1:0]     multiplier,
    input  logic [DW-1:0]     addend,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   result,
    output logic              busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DW-1:0]     a_q;
    logic [DW-1:0]     b_q;
    logic [2*DW-1:0]   acc_q;
    logic [2*DW-1:0]   acc_d;
    logic [2*DW-1:0]   partial;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [2*DW-1:0]   result_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    // Next accumulator: add the shifted multiplicand when the current multiplier bit is set.
    // The sum never exceeds 2^(2DW) - 2^DW, so the 2*DW-bit add cannot wrap.
    always_comb begin
        partial = '0;
        if (b_q[cnt_q]) begin
            partial = {{DW{1'b0}}, a_q} << cnt_q;
        end
        acc_d = acc_q + partial;
        cnt_d = cnt_q + CW'(1);
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= multiplicand;
                        b_q        <= multiplier;
                        acc_q      <= {{DW{1'b0}}, addend};
                        cnt_q      <= '0;
                        state_q    <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A new in_valid here is deliberately not looked at; the
                    // next operand can only be taken once back in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule
